// File: rtl/mux2_tx.sv
// Two-lane byte interleaver on a double-rate clock: lane pairs are buffered in a
// 2-deep FIFO and emitted lane 0 then lane 1 on consecutive edges, never split.
module mux2_tx (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    input  logic       tx_en,
    output logic       ready_out,
    output logic       phase,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [7:0] drop_count
);
    typedef enum logic {IDLE, SEND1} tx_state_t;
    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } pair_t;

    pair_t      fifo [2];
    pair_t      head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] occupancy;
    tx_state_t  state, state_next;
    logic       capture, push, pop, start, drop;

    always_comb begin
        capture   = ~phase;
        ready_out = reset & (occupancy != 2'd2);
        push      = capture & ready_out & valid_in_0 & valid_in_1;
        drop      = capture & ready_out & (valid_in_0 ^ valid_in_1);
        head      = fifo[rd_ptr];
    end

    // SEND1 is only ever entered on a capture edge, so its exit is always a second edge.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (capture && tx_en && occupancy != 2'd0) begin
                    start      = 1'b1;
                    state_next = SEND1;
                end
            end
            SEND1: begin
                pop        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            phase      <= 1'b0;
            state      <= IDLE;
            occupancy  <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            data_out   <= 8'h00;
            valid_out  <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            phase <= ~phase;
            state <= state_next;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
            if (start) begin
                data_out  <= head.d0;
                valid_out <= 1'b1;
            end else if (pop) begin
                data_out  <= head.d1;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk_2f) begin
        if (push) fifo[wr_ptr] <= {data_in_0, data_in_1};
    end
endmodule

// File: tb/tb_mux2_tx.sv
// Bench for mux2_tx: byte scoreboard plus a lane-0-first receive demux model
// that rebuilds pairs from the serial stream.
module tb_mux2_tx;
    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in_0, data_in_1;
    logic       valid_in_0, valid_in_1;
    logic       tx_en;
    logic       ready_out, phase, valid_out;
    logic [7:0] data_out, drop_count;

    mux2_tx dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_in_0  (data_in_0),
        .valid_in_0 (valid_in_0),
        .data_in_1  (data_in_1),
        .valid_in_1 (valid_in_1),
        .tx_en      (tx_en),
        .ready_out  (ready_out),
        .phase      (phase),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .drop_count (drop_count)
    );

    always #5 clk_2f = ~clk_2f;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] pair_q [$];
    int          run_len = 0;
    int          last_run = 0;
    logic        lane_sel = 1'b0;
    logic [7:0]  rx0;
    logic [15:0] rx_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard + receive demux: realigns to lane 0 whenever the stream idles.
    always @(negedge clk_2f) begin
        if (valid_out === 1'b1) begin
            chk("spurious_valid", 32'(valid_out), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("byte", 32'(data_out), 32'(exp_q.pop_front()));
            run_len++;
            if (!lane_sel) begin
                rx0      = data_out;
                lane_sel = 1'b1;
            end else begin
                lane_sel = 1'b0;
                if (pair_q.size() != 0) begin
                    rx_exp = pair_q.pop_front();
                    chk("rx_lane0", 32'(rx0), 32'(rx_exp[15:8]));
                    chk("rx_lane1", 32'(data_out), 32'(rx_exp[7:0]));
                end
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len  = 0;
            lane_sel = 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_2f);
    endtask

    task automatic wait_capture_ready(input string tag);
        int n = 0;
        while (!(phase == 1'b0 && ready_out == 1'b1) && n < 40) begin
            @(negedge clk_2f);
            n++;
        end
        chk(tag, 32'(!phase && ready_out), 1);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        wait_capture_ready("send_ready");
        data_in_0  = a;
        data_in_1  = b;
        valid_in_0 = 1'b1;
        valid_in_1 = 1'b1;
        exp_q.push_back(a);
        exp_q.push_back(b);
        pair_q.push_back({a, b});
        @(negedge clk_2f);
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    task automatic drive_single(input logic lane1);
        wait_capture_ready("single_ready");
        data_in_0  = 8'hEE;
        data_in_1  = 8'hDD;
        valid_in_0 = ~lane1;
        valid_in_1 = lane1;
        @(negedge clk_2f);
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b0;
        tx_en      = 1'b0;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        data_in_0  = 8'h00;
        data_in_1  = 8'h00;
        wait_cycles(3);
        chk("rst_ready", 32'(ready_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_phase", 32'(phase), 0);
        reset = 1'b1;
        #1;
        chk("rel_ready", 32'(ready_out), 1);
        wait_cycles(1);
        chk("resume_phase", 32'(phase), 1);

        // single pair with exact latency
        tx_en = 1'b1;
        send_pair(8'hA5, 8'h3C);
        chk("lat_t0", 32'(valid_out), 0);
        wait_cycles(1);
        chk("lat_t1", 32'(valid_out), 0);
        wait_cycles(1);
        chk("lat_d0_v", 32'(valid_out), 1);
        chk("lat_d0", 32'(data_out), 32'h0A5);
        wait_cycles(1);
        chk("lat_d1_v", 32'(valid_out), 1);
        chk("lat_d1", 32'(data_out), 32'h03C);
        wait_cycles(1);
        chk("lat_end_v", 32'(valid_out), 0);
        chk("hold_data", 32'(data_out), 32'h03C);

        // burst on consecutive capture edges
        send_pair(8'h01, 8'h02);
        send_pair(8'h03, 8'h04);
        send_pair(8'h05, 8'h06);
        wait_cycles(10);
        chk("burst_run", 32'(last_run), 6);
        chk("burst_drain", 32'(exp_q.size()), 0);

        // backpressure
        tx_en = 1'b0;
        send_pair(8'h10, 8'h11);
        send_pair(8'h12, 8'h13);
        chk("bp_full", 32'(ready_out), 0);
        n = 0;
        while (phase != 1'b0 && n < 4) begin
            @(negedge clk_2f);
            n++;
        end
        data_in_0  = 8'h14;
        data_in_1  = 8'h15;
        valid_in_0 = 1'b1;
        valid_in_1 = 1'b1;
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h15);
        pair_q.push_back(16'h1415);
        repeat (6) begin
            @(negedge clk_2f);
            chk("bp_stall_valid", 32'(valid_out), 0);
            chk("bp_stall_ready", 32'(ready_out), 0);
        end
        tx_en = 1'b1;
        wait_capture_ready("bp_accept");
        @(negedge clk_2f);
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        wait_cycles(12);
        chk("bp_ready_back", 32'(ready_out), 1);
        chk("bp_drain", 32'(exp_q.size()), 0);

        // unpaired captures and saturation
        drive_single(1'b0);
        wait_cycles(4);
        chk("drop_one", 32'(drop_count), 1);
        for (int i = 0; i < 254; i++) drive_single(i[0]);
        wait_cycles(1);
        chk("drop_255", 32'(drop_count), 255);
        drive_single(1'b1);
        wait_cycles(1);
        chk("drop_sat", 32'(drop_count), 255);
        chk("drop_no_out", 32'(exp_q.size()), 0);

        // reset while the second byte of a pair is pending
        send_pair(8'h11, 8'h22);
        n = 0;
        while (valid_out !== 1'b1 && n < 20) begin
            @(negedge clk_2f);
            n++;
        end
        chk("mid_d0", 32'(data_out), 32'h011);
        reset = 1'b0;
        @(negedge clk_2f);
        chk("mid_valid", 32'(valid_out), 0);
        chk("mid_data", 32'(data_out), 0);
        chk("mid_drop", 32'(drop_count), 0);
        chk("mid_ready_low", 32'(ready_out), 0);
        exp_q.delete();
        pair_q.delete();
        wait_cycles(2);
        reset = 1'b1;
        #1;
        chk("mid_ready_rel", 32'(ready_out), 1);
        repeat (6) begin
            @(negedge clk_2f);
            chk("mid_no_d1", 32'(valid_out), 0);
        end

        // loopback through the demux model
        for (int i = 0; i < 100; i++) begin
            send_pair(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 4));
        end
        wait_cycles(20);
        chk("loop_pairs_left", 32'(pair_q.size()), 0);
        chk("loop_bytes_left", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
